// File: rtl/uart_prog_loader.sv
// Serial bootloader: 8N1 receiver, packet parser, program-memory write port.
// Build with PROG_ACK_EN defined to add the 0x06/0x15 acknowledge transmitter on uart_tx.
module uart_prog_loader #(
  parameter int CLK_HZ       = 12500000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [15:0] PROGADD,
  output logic [15:0] PROGDATA,
  output logic        PROGWE,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        uart_tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  // Two clks of synchroniser delay are already spent when the start edge is seen.
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2 - 2);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR_H = 3'd1;
  localparam logic [2:0] S_ADDR_L = 3'd2;
  localparam logic [2:0] S_CNT    = 3'd3;
  localparam logic [2:0] S_DATA_L = 3'd4;
  localparam logic [2:0] S_DATA_H = 3'd5;
  localparam logic [2:0] S_CSUM   = 3'd6;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sr_q;
  logic          rx_vld_q, rx_ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sr_q   <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      unique case (rx_st_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == DIV_LAST) begin
            rx_cnt_q <= '0;
            rx_sr_q  <= {rx_s2_q, rx_sr_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: begin
          if (rx_cnt_q == DIV_LAST) begin
            rx_cnt_q  <= '0;
            rx_st_q   <= RX_IDLE;
            rx_vld_q  <= rx_s2_q;
            rx_ferr_q <= !rx_s2_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  logic [2:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d, padd_q, padd_d, pdat_q, pdat_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    lo_q, lo_d, sum_q, sum_d;
  logic          we_q, we_d, done_q, done_d, err_q, err_d, err_evt;
  logic [CW-1:0] to_div_q;
  logic [TW-1:0] to_bits_q;
  logic          timeout;

  assign timeout = (to_bits_q == TW'(TIMEOUT_BITS));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    padd_d  = padd_q;
    pdat_d  = pdat_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    err_evt = 1'b0;
    if (rx_ferr_q || timeout) begin
      state_d = S_IDLE;
      err_evt = 1'b1;
    end else if (rx_vld_q) begin
      if (state_q != S_IDLE && state_q != S_CSUM) sum_d = sum_q + rx_sr_q;
      unique case (state_q)
        S_IDLE: begin
          if (rx_sr_q == 8'hA5) begin
            state_d = S_ADDR_H;
            err_d   = 1'b0;
            sum_d   = '0;
          end
        end
        S_ADDR_H: begin
          addr_d  = {rx_sr_q, addr_q[7:0]};
          state_d = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_d  = {addr_q[15:8], rx_sr_q};
          state_d = S_CNT;
        end
        S_CNT: begin
          cnt_d   = (rx_sr_q == 8'h00) ? 9'd256 : {1'b0, rx_sr_q};
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          lo_d    = rx_sr_q;
          state_d = S_DATA_H;
        end
        S_DATA_H: begin
          we_d    = 1'b1;
          padd_d  = addr_q;
          pdat_d  = {rx_sr_q, lo_q};
          addr_d  = addr_q + 16'd1;
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? S_CSUM : S_DATA_L;
        end
        S_CSUM: begin
          done_d  = (rx_sr_q == sum_q);
          err_evt = (rx_sr_q != sum_q);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (err_evt) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      lo_q      <= '0;
      sum_q     <= '0;
      padd_q    <= '0;
      pdat_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      to_div_q  <= '0;
      to_bits_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      sum_q   <= sum_d;
      padd_q  <= padd_d;
      pdat_q  <= pdat_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      // Idle time between bytes of a packet, counted in bit periods.
      if (state_q == S_IDLE || rx_vld_q || timeout) begin
        to_div_q  <= '0;
        to_bits_q <= '0;
      end else if (rx_st_q == RX_IDLE) begin
        if (to_div_q == DIV_LAST) begin
          to_div_q  <= '0;
          to_bits_q <= to_bits_q + TW'(1);
        end else begin
          to_div_q <= to_div_q + CW'(1);
        end
      end
    end
  end

  assign PROGADD  = padd_q;
  assign PROGDATA = pdat_q;
  assign PROGWE   = we_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

`ifdef PROG_ACK_EN
  logic [9:0]    tx_sr_q;
  logic [3:0]    tx_bits_q;
  logic [CW-1:0] tx_cnt_q;

  // Acknowledges raised while a byte is still shifting out are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_q   <= '1;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_bits_q == 4'd0) begin
      if (done_d || err_evt) begin
        tx_sr_q   <= {1'b1, (done_d ? 8'h06 : 8'h15), 1'b0};
        tx_bits_q <= 4'd10;
        tx_cnt_q  <= '0;
      end
    end else if (tx_cnt_q == DIV_LAST) begin
      tx_cnt_q  <= '0;
      tx_sr_q   <= {1'b1, tx_sr_q[9:1]};
      tx_bits_q <= tx_bits_q - 4'd1;
    end else begin
      tx_cnt_q <= tx_cnt_q + CW'(1);
    end
  end

  assign uart_tx = tx_sr_q[0];
`else
  assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader at DIV=10; checks writes, done/err/busy, reset and (with PROG_ACK_EN) acks.
module tb_uart_prog_loader;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [15:0] PROGADD, PROGDATA;
  logic        PROGWE, busy, done, err, uart_tx;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int d0;
  logic [31:0] wq[$];
  logic [7:0]  ackq[$];
  logic [31:0] wexp;

  uart_prog_loader #(.CLK_HZ(1000000), .BAUD(100000), .TIMEOUT_BITS(64)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .PROGADD(PROGADD), .PROGDATA(PROGDATA), .PROGWE(PROGWE),
    .busy(busy), .done(done), .err(err), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (PROGWE === 1'b1) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", 32'(PROGWE), 32'h0);
      end else begin
        wexp = wq.pop_front();
        check("wr_addr", 32'(PROGADD), 32'(wexp[31:16]));
        check("wr_data", 32'(PROGDATA), 32'(wexp[15:0]));
      end
    end
  end

`ifdef PROG_ACK_EN
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      check("ack_stop", 32'(uart_tx), 32'h1);
      if (ackq.size() == 0) check("ack_unexpected", 32'(b), 32'h0);
      else check("ack_byte", 32'(b), 32'(ackq.pop_front()));
    end
  end
`endif

  task automatic expect_ack(input logic [7:0] b);
`ifdef PROG_ACK_EN
    ackq.push_back(b);
`else
    if (b == 8'h00) ackq.push_back(b);
`endif
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [15:0] a, input int n, input logic [15:0] w0,
                          input logic [15:0] w1, input bit bad);
    logic [7:0]  s;
    logic [15:0] w;
    s = a[15:8] + a[7:0] + 8'(n);
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      wq.push_back({a + 16'(i), w});
      s = s + w[7:0] + w[15:8];
      send_byte(w[7:0]);
      send_byte(w[15:8]);
    end
    if (bad) s = s + 8'd1;
    expect_ack(bad ? 8'h15 : 8'h06);
    send_byte(s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_add", 32'(PROGADD), 32'h0);
    check("rst_data", 32'(PROGDATA), 32'h0);
    check("rst_we", 32'(PROGWE), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_tx", 32'(uart_tx), 32'h1);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Good two-word packet, checksum 0x17
    d0 = done_cnt;
    send_pkt(16'h0100, 2, 16'h1234, 16'h5678, 1'b0);
    repeat (3) @(negedge clk);
    check("good_done", 32'(done_cnt - d0), 32'd1);
    check("good_err", 32'(err), 32'h0);
    check("good_busy", 32'(busy), 32'h0);
    repeat (150) @(negedge clk);

    // Same packet, checksum 0x18: writes still land, err sticky
    d0 = done_cnt;
    send_pkt(16'h0100, 2, 16'h1234, 16'h5678, 1'b1);
    repeat (3) @(negedge clk);
    check("bad_done", 32'(done_cnt - d0), 32'd0);
    check("bad_err", 32'(err), 32'h1);
    check("bad_busy", 32'(busy), 32'h0);
    repeat (200) @(negedge clk);
    check("bad_err_sticky", 32'(err), 32'h1);

    // Address wrap 0xFFFF -> 0x0000, checksum 0x03
    d0 = done_cnt;
    send_pkt(16'hFFFF, 2, 16'h0001, 16'h0002, 1'b0);
    repeat (3) @(negedge clk);
    check("wrap_done", 32'(done_cnt - d0), 32'd1);
    check("wrap_err", 32'(err), 32'h0);
    repeat (150) @(negedge clk);

    // Framing error on ADDR_L
    send_byte(8'hA5);
    send_byte(8'h01);
    check("fe_busy_before", 32'(busy), 32'h1);
    expect_ack(8'h15);
    send_byte(8'h00, 1'b0);
    check("fe_err", 32'(err), 32'h1);
    check("fe_busy", 32'(busy), 32'h0);
    repeat (150) @(negedge clk);
    d0 = done_cnt;
    send_pkt(16'h0200, 1, 16'hBEEF, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check("fe_recover_done", 32'(done_cnt - d0), 32'd1);
    check("fe_recover_err", 32'(err), 32'h0);
    repeat (150) @(negedge clk);

    // Timeout after A5 00
    send_byte(8'hA5);
    expect_ack(8'h15);
    send_byte(8'h00);
    check("to_busy_start", 32'(busy), 32'h1);
    repeat (600) @(negedge clk);
    check("to_busy_early", 32'(busy), 32'h1);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check("to_busy_end", 32'(busy), 32'h0);
    check("to_err", 32'(err), 32'h1);
    repeat (150) @(negedge clk);

    // 4-clk glitch must not start a byte; a following packet must frame cleanly
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (15) @(negedge clk);
    check("gl_busy", 32'(busy), 32'h0);
    check("gl_err", 32'(err), 32'h1);
    d0 = done_cnt;
    send_pkt(16'h0300, 1, 16'hCAFE, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check("gl_pkt_done", 32'(done_cnt - d0), 32'd1);
    repeat (150) @(negedge clk);

    // Reset in the middle of the second DATA_H byte
    wq.push_back({16'h0400, 16'h1234});
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_add", 32'(PROGADD), 32'h0);
    check("mr_data", 32'(PROGDATA), 32'h0);
    check("mr_we", 32'(PROGWE), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_done", 32'(done), 32'h0);
    check("mr_err", 32'(err), 32'h0);
    check("mr_tx", 32'(uart_tx), 32'h1);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("mr_busy_after", 32'(busy), 32'h0);

    check("wr_pending", 32'(wq.size()), 32'd0);
    check("ack_pending", 32'(ackq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial bootloader that feeds the core's program memory: receives framed packets on the UART RX pin and emits 16-bit word writes on the PROGADD/PROGDATA/PROGWE write port.
- Sits upstream of program memory, on the uart_rx_prog branch of the top-level RX split; active while the CPU is held off.
- Contains its own bit-level UART receiver, a packet parser FSM, an address/count engine and checksum verification.

Parameters:
- CLK_HZ, 12500000, frequency of clk in Hz.
- BAUD, 115200, serial bit rate. Bit period DIV = CLK_HZ/BAUD, truncated; default gives 108.
- TIMEOUT_BITS, 64, idle bit periods allowed mid-packet before the packet is aborted.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first.
- PROGADD  out  16  word address of the current write.
- PROGDATA  out  16  write data, {high byte, low byte}.
- PROGWE  out  1  one-clk write strobe; memory captures on the same clk edge.
- busy  out  1  high whenever the parser state is not IDLE.
- done  out  1  one-clk pulse when a packet's checksum matches.
- err  out  1  sticky; cleared only by rst or by the next accepted header.
- uart_tx  out  1  acknowledge output; see Optional Feature.

Behaviour:
- Reset values: PROGADD=0, PROGDATA=0, PROGWE=0, busy=0, done=0, err=0, uart_tx=1, FSM=IDLE, RX=idle.
- rst asserted mid-byte or mid-packet discards everything immediately. No write strobe is issued on the reset cycle.
- RX input path: uart_rx passes through a 2-FF synchroniser.
- RX start: a high-to-low transition while the receiver is idle starts a byte. The line is re-checked at DIV/2; if high, it was a glitch and RX returns to idle.
- RX data: 8 data bits are sampled every DIV clks from the start-bit centre.
- RX stop: the stop bit is sampled at its centre. If it is 0, the byte is discarded, the packet is aborted (FSM to IDLE) and err is set.
- RX output: a valid byte produces an internal 1-clk rx_valid with the byte value. Latency from stop-bit centre to rx_valid is 1 clk.
- Packet format: 0xA5, ADDR_H, ADDR_L, CNT, then CNT words sent as (LO, HI), then CSUM.
  - CNT=0 means 256 words.
  - CSUM is the 8-bit mod-256 sum of ADDR_H, ADDR_L, CNT and all data bytes.
- FSM states: IDLE, ADDR_H, ADDR_L, CNT, DATA_L, DATA_H, CSUM.
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 goes to ADDR_H, clears err and clears the running sum.
  - ADDR_H then ADDR_L load the address register. CNT loads the word counter (9 bits, 0 maps to 256), then go to DATA_L.
  - DATA_L latches the low byte. DATA_H latches the high byte.
- Write on DATA_H byte: on the clk after its rx_valid, PROGWE=1 for exactly 1 clk with PROGADD=addr and PROGDATA={hi,lo}.
  - PROGADD/PROGDATA are held until the next write.
  - The address increments by 1 after the write, wrapping 0xFFFF to 0x0000.
  - The counter decrements; if it reaches 0 go to CSUM, else go to DATA_L.
- Writes are committed as they arrive. A bad checksum does not undo them; it only sets err.
- CSUM byte: if it equals the running sum, done pulses 1 clk; otherwise err=1. Either way go to IDLE.
- busy is combinationally derived from the FSM state (state != IDLE).
- Timeout: while FSM != IDLE and RX is idle, count bit periods. Reaching TIMEOUT_BITS goes to IDLE with err=1. The count resets on every rx_valid.
- Simultaneous events: rst has priority over all. A timeout cannot coincide with rx_valid, since the counter resets.
- The next byte cannot arrive before a write completes: one byte time is at least 10*DIV clks.

Optional Feature:
- Macro: PROG_ACK_EN.
- When defined: a TX serialiser at the same DIV sends 0x06 after a checksum match, or 0x15 after a checksum mismatch, framing error or timeout. Each is one 8N1 byte, starting within 2 clks of done or err being raised.
  - If a new event occurs while a byte is transmitting, the new acknowledge is dropped.
- When undefined: uart_tx is tied to 1 and no TX logic is synthesised.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (DIV=10). Send A5 01 00 02 34 12 78 56 CSUM=0x17 -> PROGWE pulses twice: (PROGADD=0x0100, PROGDATA=0x1234), then (0x0101, 0x5678); done=1 for 1 clk; err=0; busy low after CSUM.
- Same packet with CSUM=0x18 -> both writes still occur; done stays 0; err=1 until the next 0xA5.
- A5 FF FF 02 01 00 02 00 CSUM=0x03 -> writes at 0xFFFF then 0x0000 (wrap); done pulses.
- Stop bit forced 0 on the ADDR_L byte -> no PROGWE; err=1; FSM=IDLE. A subsequent valid packet succeeds and clears err.
- Send A5 00 then stay idle for 64 bit periods -> busy falls and err=1. A 4-clk low glitch on an idle line produces no byte and no state change.
- With PROG_ACK_EN, repeat the first case -> uart_tx emits 0x06; repeat the second case -> uart_tx emits 0x15. rst asserted mid-DATA_H byte -> no PROGWE; all outputs return to reset values on the next clk.
